qbert_move_ctrl: RTL and testbench

- Jump controller that sits directly upstream of the Q*bert sprite/animation layer.
- Takes a debounced direction request from the NIOS/accelerometer path and the one-hot cube position, then computes the target cube, flags off-pyramid (bad) jumps and predicts the win.
- Drives the sprite layer's jump handshake through its done_move/state outputs and records the colour state of the 28 cubes.

---
 rtl/qbert_move_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_qbert_move_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qbert_move_ctrl.sv
// Q*bert jump controller: debounced direction requests, pyramid geometry,
// sprite-layer jump handshake and board progress tracking.
module qbert_move_ctrl #(
  parameter int DEBOUNCE    = 16,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_start,
  input  logic [2:0]  e_dir,
  input  logic [1:0]  e_tilt_acc,
  input  logic        done_move,
  input  logic [2:0]  state_qb,
  output logic [27:0] position_qb,
  output logic [27:0] e_next_qb,
  output logic [2:0]  e_jump_qb,
  output logic        e_bad_jump,
  output logic        e_win_qb,
  output logic [27:0] cube_done,
  output logic [15:0] jump_count
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE - 1);
  localparam logic [TW-1:0] TO_MAX = TW'(ACK_TIMEOUT - 1);
  localparam logic [2:0] QB_START = 3'b000;
  localparam logic [2:0] QB_IDLE  = 3'b010;

  typedef enum logic [2:0] {
    S_WAIT, S_ARMED, S_LAUNCH, S_FLIGHT, S_LAND
  } state_e;

  state_e st_q, st_d;

  logic [27:0] pos_q, pos_d;
  logic [27:0] nxt_q, nxt_d;
  logic [27:0] tgt_q, tgt_d;
  logic [27:0] cube_q, cube_d;
  logic [2:0]  jmp_q, jmp_d;
  logic [2:0]  pdir_q, pdir_d;
  logic        bad_q, bad_d;
  logic        win_q, win_d;
  logic [15:0] jcnt_q, jcnt_d;
  logic [CW-1:0] db_q, db_d;
  logic [TW-1:0] to_q, to_d;

  logic [3:0]  row, col, tr, tk;
  logic [4:0]  n;
  logic [27:0] tgt_c;
  logic        bad_c, win_c;
  logic        acc, go, respawn;

  // Decode the one-hot cube into (row, column) and project the move.
  always_comb begin
    row = 4'd1;
    col = 4'd1;
    n   = 5'd0;
    for (int r = 1; r <= 7; r++) begin
      for (int k = 1; k <= r; k++) begin
        if (pos_q[n]) begin
          row = 4'(r);
          col = 4'(k);
        end
        n = n + 5'd1;
      end
    end
    tr    = row;
    tk    = col;
    bad_c = 1'b1;
    unique case (1'b1)
      (e_dir == 3'd1): begin
        tr    = row + 4'd1;
        bad_c = (row == 4'd7);
      end
      (e_dir == 3'd2): begin
        tr    = row + 4'd1;
        tk    = col + 4'd1;
        bad_c = (row == 4'd7);
      end
      (e_dir == 3'd3): begin
        tr    = row - 4'd1;
        tk    = col - 4'd1;
        bad_c = (col == 4'd1);
      end
      (e_dir == 3'd4): begin
        tr    = row - 4'd1;
        bad_c = (col == row);
      end
      default: bad_c = 1'b1;
    endcase
    tgt_c = '0;
    n     = 5'd0;
    for (int r = 1; r <= 7; r++) begin
      for (int k = 1; k <= r; k++) begin
        if (!bad_c && 4'(r) == tr && 4'(k) == tk)
          tgt_c[n] = 1'b1;
        n = n + 5'd1;
      end
    end
    win_c = !bad_c && ((cube_q | tgt_c) == '1);
  end

  assign acc = (e_dir != 3'd0) && (e_dir == pdir_q) &&
               (db_q == DB_MAX);
  assign respawn = (state_qb == QB_START);
  assign go = (st_q == S_ARMED) && !respawn &&
              (e_tilt_acc == 2'b00) && acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q   <= S_WAIT;
      pos_q  <= 28'h1;
      nxt_q  <= 28'h1;
      tgt_q  <= '0;
      cube_q <= '0;
      jmp_q  <= '0;
      pdir_q <= '0;
      bad_q  <= 1'b0;
      win_q  <= 1'b0;
      jcnt_q <= '0;
      db_q   <= '0;
      to_q   <= '0;
    end else begin
      st_q   <= st_d;
      pos_q  <= pos_d;
      nxt_q  <= nxt_d;
      tgt_q  <= tgt_d;
      cube_q <= cube_d;
      jmp_q  <= jmp_d;
      pdir_q <= pdir_d;
      bad_q  <= bad_d;
      win_q  <= win_d;
      jcnt_q <= jcnt_d;
      db_q   <= db_d;
      to_q   <= to_d;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      S_WAIT:
        if (state_qb == QB_IDLE && done_move) st_d = S_ARMED;
      S_ARMED:
        if (respawn)  st_d = S_WAIT;
        else if (go)  st_d = S_LAUNCH;
      S_LAUNCH:
        if (!done_move)           st_d = S_FLIGHT;
        else if (to_q == TO_MAX)  st_d = S_ARMED;
      S_FLIGHT:
        if (done_move) st_d = S_LAND;
      S_LAND:  st_d = S_WAIT;
      default: st_d = S_WAIT;
    endcase
    if (e_start) st_d = S_WAIT;
  end

  always_comb begin
    pos_d  = pos_q;
    nxt_d  = nxt_q;
    tgt_d  = tgt_q;
    cube_d = cube_q;
    jmp_d  = jmp_q;
    pdir_d = pdir_q;
    bad_d  = bad_q;
    win_d  = win_q;
    jcnt_d = jcnt_q;
    db_d   = db_q;
    to_d   = to_q;
    // Debounce runs only while a new request may be taken.
    if (st_q == S_WAIT || st_q == S_ARMED) begin
      pdir_d = e_dir;
      if (st_q == S_ARMED && e_tilt_acc != 2'b00)
        db_d = '0;
      else if (e_dir == 3'd0 || e_dir != pdir_q)
        db_d = '0;
      else if (db_q != DB_MAX)
        db_d = db_q + 1'b1;
    end
    unique case (st_q)
      S_WAIT, S_ARMED: begin
        if (respawn) begin
          pos_d = 28'h1;
          nxt_d = 28'h1;
        end else if (go) begin
          jmp_d = e_dir;
          nxt_d = tgt_c;
          tgt_d = tgt_c;
          bad_d = bad_c;
          win_d = win_q | win_c;
          db_d  = '0;
          to_d  = '0;
        end
      end
      S_LAUNCH: begin
        if (!done_move) begin
          nxt_d = pos_q;
        end else if (to_q == TO_MAX) begin
          nxt_d = pos_q;
          bad_d = 1'b0;
          win_d = 1'b0;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      S_LAND: begin
        db_d = '0;
        if (!bad_q) begin
          pos_d  = tgt_q;
          nxt_d  = tgt_q;
          cube_d = cube_q | tgt_q;
          if (jcnt_q != 16'hFFFF) jcnt_d = jcnt_q + 16'd1;
        end else begin
          pos_d = 28'h1;
          nxt_d = 28'h1;
          bad_d = 1'b0;
        end
      end
      default: ;
    endcase
    if (e_start) begin
      pos_d  = 28'h1;
      nxt_d  = 28'h1;
      tgt_d  = '0;
      cube_d = '0;
      jmp_d  = '0;
      pdir_d = '0;
      bad_d  = 1'b0;
      win_d  = 1'b0;
      jcnt_d = '0;
      db_d   = '0;
      to_d   = '0;
    end
  end

  assign position_qb = pos_q;
  assign e_next_qb   = nxt_q;
  assign e_jump_qb   = jmp_q;
  assign e_bad_jump  = bad_q;
  assign e_win_qb    = win_q;
  assign cube_done   = cube_q;
  assign jump_count  = jcnt_q;

endmodule

// File: tb/tb_qbert_move_ctrl.sv
// Bench for qbert_move_ctrl: a table-driven pyramid tour plus
// hand-written handshake, timeout, restart and reset sequences.
module tb_qbert_move_ctrl;

  localparam int DEBOUNCE    = 16;
  localparam int ACK_TIMEOUT = 1024;
  localparam logic [2:0] ST_START = 3'b000;
  localparam logic [2:0] ST_JUMP  = 3'b001;
  localparam logic [2:0] ST_IDLE  = 3'b010;

  logic        clk;
  logic        reset;
  logic        e_start;
  logic [2:0]  e_dir;
  logic [1:0]  e_tilt_acc;
  logic        done_move;
  logic [2:0]  state_qb;
  logic [27:0] position_qb;
  logic [27:0] e_next_qb;
  logic [2:0]  e_jump_qb;
  logic        e_bad_jump;
  logic        e_win_qb;
  logic [27:0] cube_done;
  logic [15:0] jump_count;

  qbert_move_ctrl #(
    .DEBOUNCE   (DEBOUNCE),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .e_start    (e_start),
    .e_dir      (e_dir),
    .e_tilt_acc (e_tilt_acc),
    .done_move  (done_move),
    .state_qb   (state_qb),
    .position_qb(position_qb),
    .e_next_qb  (e_next_qb),
    .e_jump_qb  (e_jump_qb),
    .e_bad_jump (e_bad_jump),
    .e_win_qb   (e_win_qb),
    .cube_done  (cube_done),
    .jump_count (jump_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int dir;
    int tgt;
    int win;
  } vec_t;

  vec_t        tv[39];
  int          nchk;
  int          nerr;
  int          mpos;
  logic [27:0] mdone;
  int          mcnt;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_launch();
    int n;
    n = 0;
    while (e_next_qb == position_qb && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("launch_seen", 32'(n < 200), 32'd1);
  endtask

  task automatic do_jump(input int dir, input int tgt,
                         input int win, input bit cw);
    logic [27:0] oh;
    oh = (tgt < 0) ? 28'd0 : (28'd1 << tgt);
    e_dir = 3'(dir);
    wait_launch();
    e_dir = 3'd0;
    chk("target", 32'(e_next_qb), 32'(oh));
    chk("jump_dir", 32'(e_jump_qb), 32'(dir));
    chk("bad_flag", 32'(e_bad_jump), 32'(tgt < 0));
    if (cw) chk("win_flag", 32'(e_win_qb), 32'(win));
    done_move = 1'b0;
    state_qb  = ST_JUMP;
    repeat (2) @(negedge clk);
    chk("ack_hold", 32'(e_next_qb), 32'(28'd1 << mpos));
    done_move = 1'b1;
    state_qb  = ST_IDLE;
    repeat (2) @(negedge clk);
    if (tgt >= 0) begin
      mpos  = tgt;
      mdone = mdone | oh;
      mcnt++;
    end else begin
      mpos = 0;
    end
    chk("land_pos", 32'(position_qb), 32'(28'd1 << mpos));
    chk("land_next", 32'(e_next_qb), 32'(28'd1 << mpos));
    chk("land_bad", 32'(e_bad_jump), 32'd0);
    chk("land_cubes", 32'(cube_done), 32'(mdone));
    chk("land_count", 32'(jump_count), 32'(mcnt));
  endtask

  task automatic pulse_start();
    e_start = 1'b1;
    @(negedge clk);
    e_start = 1'b0;
    mpos  = 0;
    mdone = '0;
    mcnt  = 0;
  endtask

  initial begin
    int n;
    tv = '{
      '{4, -1, 0},
      '{1, 1, 0}, '{4, 0, 0}, '{2, 2, 0}, '{2, 5, 0},
      '{3, 2, 0}, '{1, 4, 0}, '{3, 1, 0}, '{1, 3, 0},
      '{1, 6, 0}, '{4, 3, 0}, '{2, 7, 0}, '{4, 4, 0},
      '{2, 8, 0}, '{4, 5, 0}, '{2, 9, 0},
      '{2, 14, 0}, '{3, 9, 0}, '{1, 13, 0}, '{3, 8, 0},
      '{1, 12, 0}, '{3, 7, 0}, '{1, 11, 0}, '{3, 6, 0},
      '{1, 10, 0},
      '{1, 15, 0}, '{1, 21, 0}, '{4, 15, 0}, '{2, 22, 0},
      '{4, 16, 0}, '{2, 23, 0}, '{4, 17, 0}, '{2, 24, 0},
      '{4, 18, 0}, '{2, 25, 0}, '{4, 19, 0}, '{2, 26, 0},
      '{4, 20, 0},
      '{2, 27, 1}
    };
    nchk = 0;
    nerr = 0;
    mpos  = 0;
    mdone = '0;
    mcnt  = 0;
    reset      = 1'b1;
    e_start    = 1'b0;
    e_dir      = 3'd0;
    e_tilt_acc = 2'd0;
    done_move  = 1'b1;
    state_qb   = ST_IDLE;
    repeat (2) @(negedge clk);
    chk("rst_pos", 32'(position_qb), 32'h1);
    chk("rst_next", 32'(e_next_qb), 32'h1);
    chk("rst_jump", 32'(e_jump_qb), 32'd0);
    chk("rst_flags", 32'({e_bad_jump, e_win_qb}), 32'd0);
    chk("rst_cubes", 32'(cube_done), 32'd0);
    chk("rst_count", 32'(jump_count), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // first landing, then an off-pyramid jump from (2,1)
    do_jump(1, 1, 0, 1'b1);
    do_jump(3, -1, 0, 1'b1);

    e_dir = 3'd2;
    repeat (DEBOUNCE - 1) @(negedge clk);
    e_dir = 3'd0;
    repeat (20) @(negedge clk);
    chk("short_hold", 32'(e_next_qb), 32'(position_qb));
    chk("short_pos", 32'(position_qb), 32'h1);

    e_tilt_acc = 2'd1;
    e_dir      = 3'd1;
    repeat (30) @(negedge clk);
    chk("tilt_block", 32'(e_next_qb), 32'(position_qb));
    e_tilt_acc = 2'd0;
    repeat (5) @(negedge clk);
    chk("tilt_hold0", 32'(e_next_qb), 32'(position_qb));
    e_dir = 3'd0;
    repeat (3) @(negedge clk);

    pulse_start();
    chk("start_cubes", 32'(cube_done), 32'd0);
    chk("start_count", 32'(jump_count), 32'd0);

    for (int i = 0; i < 39; i++)
      do_jump(tv[i].dir, tv[i].tgt, tv[i].win, 1'b1);
    chk("win_held", 32'(e_win_qb), 32'd1);
    chk("all_cubes", 32'(cube_done), 32'hFFFFFFF);

    do_jump(1, -1, 0, 1'b0);

    pulse_start();
    chk("win_clear", 32'(e_win_qb), 32'd0);
    @(negedge clk);

    // bad launch never acknowledged by the sprite layer
    e_dir = 3'd3;
    wait_launch();
    e_dir = 3'd0;
    chk("to_target", 32'(e_next_qb), 32'd0);
    chk("to_bad_set", 32'(e_bad_jump), 32'd1);
    n = 0;
    while (e_next_qb != position_qb && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycles", 32'(n), 32'(ACK_TIMEOUT));
    chk("to_next", 32'(e_next_qb), 32'h1);
    chk("to_bad_clr", 32'(e_bad_jump), 32'd0);

    do_jump(1, 1, 0, 1'b1);
    state_qb = ST_START;
    @(negedge clk);
    state_qb = ST_IDLE;
    mpos = 0;
    chk("respawn_pos", 32'(position_qb), 32'h1);
    chk("respawn_next", 32'(e_next_qb), 32'h1);
    chk("respawn_cubes", 32'(cube_done), 32'(mdone));
    @(negedge clk);

    // restart while the sprite is in the air
    e_dir = 3'd1;
    wait_launch();
    e_dir     = 3'd0;
    done_move = 1'b0;
    state_qb  = ST_JUMP;
    repeat (2) @(negedge clk);
    pulse_start();
    chk("fl_pos", 32'(position_qb), 32'h1);
    chk("fl_next", 32'(e_next_qb), 32'h1);
    chk("fl_jump", 32'(e_jump_qb), 32'd0);
    chk("fl_cubes", 32'(cube_done), 32'd0);
    chk("fl_count", 32'(jump_count), 32'd0);
    done_move = 1'b1;
    state_qb  = ST_IDLE;
    repeat (4) @(negedge clk);
    chk("fl_noland", 32'(position_qb), 32'h1);
    chk("fl_nocount", 32'(jump_count), 32'd0);

    do_jump(1, 1, 0, 1'b1);
    e_dir = 3'd2;
    wait_launch();
    e_dir = 3'd0;
    chk("ar_target", 32'(e_next_qb), 32'h10);
    #2 reset = 1'b1;
    #1;
    chk("ar_pos", 32'(position_qb), 32'h1);
    chk("ar_next", 32'(e_next_qb), 32'h1);
    chk("ar_jump", 32'(e_jump_qb), 32'd0);
    chk("ar_flags", 32'({e_bad_jump, e_win_qb}), 32'd0);
    chk("ar_cubes", 32'(cube_done), 32'd0);
    chk("ar_count", 32'(jump_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
